// File: rtl/gp_timer_array.sv
// gp_timer_array: NCH prescaled down-counters behind a 16-bit register port, stepped by a
// synchronised 1 MHz reference tick (or cpuclk), with one combined active-low interrupt.
module gp_timer_array #(
  parameter int NCH   = 4,
  parameter int WIDTH = 24
) (
  input  logic           cpuclk,
  input  logic           rst_n,
  input  logic           tclk,
  input  logic           wr_en,
  input  logic           rd_en,
  input  logic [5:0]     addr,
  input  logic [15:0]    wdata,
  output logic [15:0]    rdata,
  output logic [NCH-1:0] pend,
  output logic           int_n
);

  localparam logic [2:0] R_PRESET_L = 3'd0;
  localparam logic [2:0] R_PRESET_H = 3'd1;
  localparam logic [2:0] R_VALUE_L  = 3'd2;
  localparam logic [2:0] R_VALUE_H  = 3'd3;
  localparam logic [2:0] R_CTRL     = 3'd4;
  localparam logic [2:0] R_PRESCALE = 3'd5;

  logic             tsync_p0, tsync_p1, tsync_p2;
  logic             tick;

  logic [WIDTH-1:0] preset   [NCH];
  logic [WIDTH-1:0] cnt      [NCH];
  logic [7:0]       pc       [NCH];
  logic [7:0]       prescale [NCH];
  logic [15:0]      shadow   [NCH];
  logic [NCH-1:0]   en, mode, ie, src, pend_q;

  logic [31:0]      preset_ext [NCH];
  logic [31:0]      cnt_ext    [NCH];
  logic [NCH-1:0]   hit, ctrl_wr, adv, step, load, kill, expire;
  logic [15:0]      rd_mux;

  // Stage p0..p2: two-flop synchroniser, third flop only for rising-edge detect
  always_ff @(posedge cpuclk or negedge rst_n) begin
    if (!rst_n) begin
      tsync_p0 <= 1'b0;
      tsync_p1 <= 1'b0;
      tsync_p2 <= 1'b0;
    end else begin
      tsync_p0 <= tclk;
      tsync_p1 <= tsync_p0;
      tsync_p2 <= tsync_p1;
    end
  end

  assign tick = tsync_p1 & ~tsync_p2;

  // A CTRL write clearing en, or a load, pre-empts any step due on the same edge.
  always_comb begin
    hit     = '0;
    ctrl_wr = '0;
    adv     = '0;
    step    = '0;
    load    = '0;
    kill    = '0;
    expire  = '0;
    for (int i = 0; i < NCH; i++) begin
      preset_ext[i] = 32'(preset[i]);
      cnt_ext[i]    = 32'(cnt[i]);
      hit[i]        = (addr[5:3] == 3'(i));
      ctrl_wr[i]    = wr_en & hit[i] & (addr[2:0] == R_CTRL);
      adv[i]        = en[i] & (src[i] | tick);
      step[i]       = adv[i] & (pc[i] == prescale[i]);
      load[i]       = ctrl_wr[i] & ((wdata[0] & ~en[i]) | wdata[4]);
      kill[i]       = ctrl_wr[i] & ~wdata[0];
      expire[i]     = step[i] & ~load[i] & ~kill[i] & (cnt[i] == '0);
    end
  end

  always_ff @(posedge cpuclk or negedge rst_n) begin
    if (!rst_n) begin
      en     <= '0;
      mode   <= '0;
      ie     <= '0;
      src    <= '0;
      pend_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        preset[i]   <= '0;
        cnt[i]      <= '0;
        pc[i]       <= '0;
        prescale[i] <= '0;
        shadow[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_en && hit[i]) begin
          case (addr[2:0])
            R_PRESET_L: preset[i] <= WIDTH'({preset_ext[i][31:16], wdata});
            R_PRESET_H: preset[i] <= WIDTH'({wdata, preset_ext[i][15:0]});
            R_CTRL: begin
              en[i]   <= wdata[0];
              mode[i] <= wdata[1];
              ie[i]   <= wdata[2];
              src[i]  <= wdata[5];
            end
            R_PRESCALE: prescale[i] <= wdata[7:0];
            default: ;
          endcase
        end
        if (expire[i] && mode[i] && !ctrl_wr[i])
          en[i] <= 1'b0;

        if (load[i]) begin
          cnt[i] <= preset[i];
          pc[i]  <= '0;
        end else if (adv[i] && !kill[i]) begin
          pc[i] <= step[i] ? 8'd0 : pc[i] + 8'd1;
          if (step[i]) begin
            if (cnt[i] != '0)
              cnt[i] <= cnt[i] - WIDTH'(1);
            else if (!mode[i])
              cnt[i] <= preset[i];
          end
        end

        if (expire[i])
          pend_q[i] <= 1'b1;
        else if (ctrl_wr[i] && wdata[3])
          pend_q[i] <= 1'b0;

        if (rd_en && hit[i] && (addr[2:0] == R_VALUE_L))
          shadow[i] <= cnt_ext[i][31:16];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NCH; i++) begin
      if (hit[i]) begin
        case (addr[2:0])
          R_PRESET_L: rd_mux = preset_ext[i][15:0];
          R_PRESET_H: rd_mux = preset_ext[i][31:16];
          R_VALUE_L:  rd_mux = cnt_ext[i][15:0];
          R_VALUE_H:  rd_mux = shadow[i];
          R_CTRL:     rd_mux = {10'd0, src[i], 1'b0, pend_q[i], ie[i], mode[i], en[i]};
          R_PRESCALE: rd_mux = {8'd0, prescale[i]};
          default:    rd_mux = '0;
        endcase
      end
    end
  end

  // Output stage: registered read data and interrupt line
  always_ff @(posedge cpuclk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      int_n <= 1'b1;
    end else begin
      if (rd_en)
        rdata <= rd_mux;
      int_n <= ~|(pend_q & ie);
    end
  end

  assign pend = pend_q;

endmodule

// File: tb/tb_gp_timer_array.sv
// Directed bench for gp_timer_array: register access, tick counting, one-shot/periodic,
// shadow coherency, simultaneous-event priorities, interrupt combining and async reset.
module tb_gp_timer_array;

  localparam int NCH   = 4;
  localparam int WIDTH = 24;

  logic           cpuclk = 1'b0;
  logic           rst_n  = 1'b0;
  logic           tclk   = 1'b0;
  logic           wr_en  = 1'b0;
  logic           rd_en  = 1'b0;
  logic [5:0]     addr   = '0;
  logic [15:0]    wdata  = '0;
  logic [15:0]    rdata;
  logic [NCH-1:0] pend;
  logic           int_n;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] rv;

  gp_timer_array #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .cpuclk(cpuclk),
    .rst_n (rst_n),
    .tclk  (tclk),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .pend  (pend),
    .int_n (int_n)
  );

  always #5 cpuclk = ~cpuclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input int ch, input int r, input logic [15:0] d);
    @(negedge cpuclk);
    addr  = {ch[2:0], r[2:0]};
    wdata = d;
    wr_en = 1'b1;
    @(negedge cpuclk);
    wr_en = 1'b0;
  endtask

  task automatic reg_rd(input int ch, input int r, output logic [15:0] d);
    @(negedge cpuclk);
    addr  = {ch[2:0], r[2:0]};
    rd_en = 1'b1;
    @(negedge cpuclk);
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic tclk_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge cpuclk);
      tclk = 1'b1;
      repeat (4) @(negedge cpuclk);
      tclk = 1'b0;
      repeat (4) @(negedge cpuclk);
    end
  endtask

  initial begin
    repeat (3) @(negedge cpuclk);
    check("reset_rdata", 32'(rdata), 32'h0);
    check("reset_pend",  32'(pend),  32'h0);
    check("reset_int_n", 32'(int_n), 32'h1);
    rst_n = 1'b1;
    reg_rd(1, 4, rv); check("reset_ctrl1", 32'(rv), 32'h0);

    // Reserved registers and absent channels
    reg_wr(0, 6, 16'hABCD);
    reg_rd(0, 6, rv); check("reg6_zero", 32'(rv), 32'h0);
    reg_wr(5, 0, 16'h1234);
    reg_rd(5, 0, rv); check("ch5_zero", 32'(rv), 32'h0);

    // Channel 0: periodic, preset 4, every tick
    reg_wr(0, 0, 16'd4);
    reg_wr(0, 5, 16'd0);
    reg_wr(0, 4, 16'h0005);
    tclk_ticks(1);
    reg_rd(0, 2, rv); check("ch0_cnt_t1", 32'(rv), 32'd3);
    tclk_ticks(3);
    reg_rd(0, 2, rv); check("ch0_cnt_t4", 32'(rv), 32'd0);
    check("ch0_pend_t4", 32'(pend), 32'h0);
    tclk_ticks(1);
    reg_rd(0, 2, rv); check("ch0_reload", 32'(rv), 32'd4);
    check("ch0_pend_t5", 32'(pend), 32'b0001);
    check("ch0_int_low", 32'(int_n), 32'h0);
    reg_rd(0, 4, rv); check("ch0_ctrl", 32'(rv), 32'h000D);
    reg_wr(0, 4, 16'h000D);
    check("ch0_w1c_pend", 32'(pend), 32'h0);
    check("ch0_int_lag", 32'(int_n), 32'h0);
    @(negedge cpuclk);
    check("ch0_int_high", 32'(int_n), 32'h1);
    reg_wr(0, 4, 16'h0000);

    // Channel 1: one-shot, preset 2, prescale 2 -> expires on tick 9
    reg_wr(1, 0, 16'd2);
    reg_wr(1, 5, 16'd2);
    reg_wr(1, 4, 16'h0003);
    tclk_ticks(8);
    check("ch1_pend_t8", 32'(pend), 32'h0);
    reg_rd(1, 2, rv); check("ch1_cnt_t8", 32'(rv), 32'd0);
    reg_rd(1, 4, rv); check("ch1_ctrl_t8", 32'(rv), 32'h0003);
    tclk_ticks(1);
    check("ch1_pend_t9", 32'(pend), 32'b0010);
    reg_rd(1, 4, rv); check("ch1_ctrl_t9", 32'(rv), 32'h000A);
    tclk_ticks(3);
    reg_rd(1, 2, rv); check("ch1_cnt_idle", 32'(rv), 32'd0);
    reg_rd(1, 4, rv); check("ch1_ctrl_idle", 32'(rv), 32'h000A);
    check("ch1_int_n", 32'(int_n), 32'h1);

    // Channel 2: upper bits change between the L and H reads; H must come from the shadow
    reg_wr(2, 0, 16'h0010);
    reg_wr(2, 1, 16'h0012);
    reg_rd(2, 1, rv); check("ch2_preset_h", 32'(rv), 32'h0012);
    reg_rd(2, 0, rv); check("ch2_preset_l", 32'(rv), 32'h0010);
    reg_wr(2, 5, 16'd0);
    reg_wr(2, 4, 16'h0021);
    reg_rd(2, 2, rv); check("ch2_value_l", 32'(rv), 32'h000F);
    repeat (100) @(negedge cpuclk);
    reg_rd(2, 3, rv); check("ch2_shadow_h", 32'(rv), 32'h0012);
    reg_wr(2, 1, 16'hFFFF);
    reg_rd(2, 1, rv); check("ch2_preset_h_mask", 32'(rv), 32'h00FF);
    reg_wr(2, 4, 16'h0000);

    // Channel 3: pend W1C on an expiry edge, then load on a step edge
    reg_wr(3, 0, 16'd0);
    reg_wr(3, 1, 16'd0);
    reg_wr(3, 5, 16'd0);
    reg_wr(3, 4, 16'h0025);
    repeat (2) @(negedge cpuclk);
    check("ch3_pend_set", 32'(pend[3]), 32'h1);
    reg_wr(3, 4, 16'h002D);
    check("ch3_w1c_vs_expiry", 32'(pend[3]), 32'h1);
    @(negedge cpuclk);
    check("ch3_int_stays_low", 32'(int_n), 32'h0);
    reg_wr(3, 4, 16'h0008);
    check("ch3_disable_clear", 32'(pend[3]), 32'h0);
    @(negedge cpuclk);
    check("ch3_int_high", 32'(int_n), 32'h1);
    reg_wr(3, 0, 16'd10);
    reg_wr(3, 5, 16'd3);
    reg_wr(3, 4, 16'h0021);
    repeat (2) @(negedge cpuclk);
    reg_wr(3, 4, 16'h0031);
    reg_rd(3, 2, rv); check("ch3_load_wins", 32'(rv), 32'd10);
    reg_wr(3, 4, 16'h0000);

    // All channels with presets 1,2,3,5; interrupt enabled on channel 2 only
    reg_wr(0, 0, 16'd1); reg_wr(1, 0, 16'd2); reg_wr(2, 0, 16'd3); reg_wr(3, 0, 16'd5);
    for (int c = 0; c < NCH; c++) begin
      reg_wr(c, 1, 16'd0);
      reg_wr(c, 5, 16'd0);
    end
    reg_wr(0, 4, 16'h0009); reg_wr(1, 4, 16'h0009);
    reg_wr(2, 4, 16'h000D); reg_wr(3, 4, 16'h0009);
    check("all_pend_start", 32'(pend), 32'h0);
    tclk_ticks(2);
    check("all_pend_t2", 32'(pend), 32'b0001);
    check("all_int_t2", 32'(int_n), 32'h1);
    tclk_ticks(2);
    check("all_pend_t4", 32'(pend), 32'b0111);
    check("all_int_t4", 32'(int_n), 32'h0);
    reg_wr(2, 4, 16'h000D);
    @(negedge cpuclk);
    check("all_int_clr", 32'(int_n), 32'h1);
    tclk_ticks(2);
    check("all_pend_t6", 32'(pend), 32'b1011);
    check("all_int_t6", 32'(int_n), 32'h1);
    tclk_ticks(2);
    check("all_pend_t8", 32'(pend), 32'b1111);
    check("all_int_t8", 32'(int_n), 32'h0);

    // Asynchronous reset mid-count
    reg_rd(3, 0, rv); check("pre_reset_rd", 32'(rv), 32'd5);
    @(negedge cpuclk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rdata", 32'(rdata), 32'h0);
    check("async_pend",  32'(pend),  32'h0);
    check("async_int_n", 32'(int_n), 32'h1);
    @(negedge cpuclk);
    rst_n = 1'b1;
    reg_rd(0, 4, rv); check("post_reset_ctrl", 32'(rv), 32'h0);
    tclk_ticks(3);
    reg_rd(0, 2, rv); check("post_reset_cnt", 32'(rv), 32'h0);
    reg_rd(0, 0, rv); check("post_reset_preset", 32'(rv), 32'h0);
    check("post_reset_pend", 32'(pend), 32'h0);
    check("post_reset_int", 32'(int_n), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
